debounce_array: RTL
===================

Name: debounce_array

Overview:
Parametrised multi-channel successor to the single-button debouncer. Each channel has:
- a 2-flop synchroniser;
- an independent, configurable-length stability counter, producing a clean level plus one-cycle press/release strobes;
- long-press detection, with optional auto-repeat.

The block sits between raw board buttons and game-control logic (jump/duck/start), so consumers get edge events without their own edge detectors.

Parameters:
N_CH, 4, number of independent button channels.
DB_CYCLES, 65536, consecutive mismatching cycles required before the debounced level flips; legal range 2..2^24.
ACTIVE_LOW, 0, 1 = raw inputs are active-low; inversion is applied after synchronisation.
HOLD_CYCLES, 25000000, cycles of continuous press (counted from the press strobe) before hold_o fires; legal range >=2.
REPEAT_EN, 1, 1 = generate rpt_o strobes after hold; 0 = rpt_o tied 0.
REPEAT_CYCLES, 5000000, auto-repeat period after hold; legal range >=2.

Ports:
clk  in  1  system clock; all logic on posedge.
rst_n  in  1  asynchronous active-low reset.
btn_raw  in  N_CH  unsynchronised button inputs, bit i = channel i.
btn_level  out  N_CH  debounced level, 1 = pressed (after polarity).
press_o  out  N_CH  one-cycle strobe when btn_level rises.
release_o  out  N_CH  one-cycle strobe when btn_level falls.
hold_o  out  N_CH  one-cycle strobe at long-press threshold.
rpt_o  out  N_CH  one-cycle auto-repeat strobes.

Behaviour:
- Reset, asynchronous with rst_n=0:
  - Sync flops load the idle raw value (ACTIVE_LOW ? 1 : 0), so no spurious event occurs after release.
  - All counters = 0; every output = 0.
  - Reset mid-count discards the partial count; no strobe is emitted on reset assertion or deassertion.
- Synchroniser: s0 <= btn_raw; s1 <= s0. Then p = s1 XOR ACTIVE_LOW.
- Debounce counter per channel:
  - Width = clog2(DB_CYCLES).
  - If p == btn_level: counter <= 0.
  - Else if counter == DB_CYCLES-1: btn_level <= ~btn_level and counter <= 0.
  - Else: counter <= counter + 1.
  - A mismatch shorter than DB_CYCLES cycles never flips the level.
- Latency: raw held stable from before edge k changes btn_level at edge k+1+DB_CYCLES. The 2 sync stages plus the count give DB_CYCLES+2 edges in total.
- Strobes:
  - press_o and release_o are registered and asserted in the same cycle that btn_level takes its new value.
  - They are high for exactly one cycle.
  - They never coincide on one channel.
- Hold/repeat counter per channel:
  - Width = clog2(max(HOLD_CYCLES, REPEAT_CYCLES)).
  - States: IDLE, ARMED, REPEAT.
  - IDLE -> ARMED on press (counter cleared).
  - In ARMED, the counter increments each cycle. At counter == HOLD_CYCLES-1: hold_o = 1 for one cycle, counter cleared, next state is REPEAT if REPEAT_EN else IDLE-wait.
  - IDLE-wait means no further strobes until release.
  - Net timing: press strobe at cycle T gives hold_o at T+HOLD_CYCLES.
  - In REPEAT, rpt_o pulses at counter == REPEAT_CYCLES-1 and the counter wraps to 0. Strobes land at T+HOLD_CYCLES+j*REPEAT_CYCLES, j>=1, unbounded.
  - Release, from any state, forces IDLE and clears the counter in the release_o cycle. A release in the same cycle a hold or repeat would fire suppresses that strobe; release wins.
- Channels are fully independent. Simultaneous events on different channels all assert in the same cycle.
- No wrap-around hazard: every counter is cleared before it can exceed its terminal value.

Test Plan:
All tests use N_CH=2, DB_CYCLES=4, HOLD_CYCLES=10, REPEAT_EN=1, REPEAT_CYCLES=3, ACTIVE_LOW=0.
1. Clean press: btn_raw[0] 0->1 before edge 1, held → btn_level[0]=1 and press_o[0]=1 at edge 6 only; channel 1 all outputs stay 0.
2. Bounce: btn_raw[0] pulses 1 for 3 cycles, then 0, repeated 5 times → btn_level[0] stays 0; no strobes.
3. Long press: hold 40 cycles after press strobe at edge T → hold_o[0] at T+10; rpt_o[0] at T+13, T+16, T+19, and so on; release → release_o[0] at release+6, no further rpt_o.
4. Release at the hold boundary: release such that release_o lands at T+10 → hold_o[0] never asserts.
5. Async reset mid-count: assert rst_n=0 for 1 cycle while channel 0 counter=3 → all outputs 0 immediately; press requires a full 6 edges after reset release; no strobe at reset edges.
6. ACTIVE_LOW=1 variant: btn_raw idle 1 after reset → no events; drive 0 → press_o at edge 6, btn_level=1; both channels pressed simultaneously → both press_o in the same cycle.

Source files
------------

// File: rtl/debounce_array.sv
// debounce_array
//   Multi-channel button conditioner. Each channel runs its raw input through
//   a 2-flop synchroniser and a polarity fix-up. A stability counter then
//   produces a clean level plus one-cycle press/release strobes. A
//   hold/repeat sequencer adds a long-press strobe and optional periodic
//   auto-repeat strobes while the button stays down.
// Ports:
//   clk        in  1     system clock, all logic on posedge
//   rst_n      in  1     asynchronous active-low reset
//   btn_raw    in  N_CH  unsynchronised button inputs (bit i = channel i)
//   btn_level  out N_CH  debounced level, 1 = pressed
//   press_o    out N_CH  one-cycle strobe when btn_level rises
//   release_o  out N_CH  one-cycle strobe when btn_level falls
//   hold_o     out N_CH  one-cycle strobe at the long-press threshold
//   rpt_o      out N_CH  one-cycle auto-repeat strobes after hold
module debounce_array #(
   parameter int N_CH          = 4,
   parameter int DB_CYCLES     = 65536,
   parameter int ACTIVE_LOW    = 0,
   parameter int HOLD_CYCLES   = 25000000,
   parameter int REPEAT_EN     = 1,
   parameter int REPEAT_CYCLES = 5000000
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N_CH-1:0] btn_raw,
   output logic [N_CH-1:0] btn_level,
   output logic [N_CH-1:0] press_o,
   output logic [N_CH-1:0] release_o,
   output logic [N_CH-1:0] hold_o,
   output logic [N_CH-1:0] rpt_o
);

   localparam int DBW  = $clog2(DB_CYCLES);
   localparam int HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int HW   = $clog2(HMAX);

   localparam logic            IDLE_RAW    = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
   localparam logic            RPT_ON      = (REPEAT_EN != 0) ? 1'b1 : 1'b0;
   localparam logic [DBW-1:0]  DB_LAST     = DBW'(DB_CYCLES - 1);
   localparam logic [HW-1:0]   HOLD_LAST   = HW'(HOLD_CYCLES - 1);
   localparam logic [HW-1:0]   REPEAT_LAST = HW'(REPEAT_CYCLES - 1);

   typedef enum logic [1:0] {
      HS_IDLE   = 2'd0,
      HS_ARMED  = 2'd1,
      HS_REPEAT = 2'd2
   } hstate_t;

   logic [N_CH-1:0] sync0_r;
   logic [N_CH-1:0] sync1_r;
   logic [N_CH-1:0] pressed_s;

   // Two-flop synchroniser; resets to the idle raw level so that leaving
   // reset never looks like a button edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync0_r <= {N_CH{IDLE_RAW}};
         sync1_r <= {N_CH{IDLE_RAW}};
      end else begin
         sync0_r <= btn_raw;
         sync1_r <= sync0_r;
      end
   end

   assign pressed_s = sync1_r ^ {N_CH{IDLE_RAW}};

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      logic [DBW-1:0] db_cnt_r;
      logic           level_r;
      logic           press_r;
      logic           release_r;
      logic           flip_s;
      logic           press_ev_s;
      logic           release_ev_s;
      hstate_t        state_r;
      hstate_t        state_nx_s;
      logic [HW-1:0]  hcnt_r;
      logic [HW-1:0]  hcnt_nx_s;
      logic           hold_nx_s;
      logic           rpt_nx_s;
      logic           hold_r;
      logic           rpt_r;

      // The level flips on the DB_CYCLES-th consecutive mismatching cycle.
      assign flip_s       = (pressed_s[i] != level_r) && (db_cnt_r == DB_LAST);
      assign press_ev_s   = flip_s & ~level_r;
      assign release_ev_s = flip_s &  level_r;

      // Stability counter, debounced level and press/release strobes.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            db_cnt_r  <= '0;
            level_r   <= 1'b0;
            press_r   <= 1'b0;
            release_r <= 1'b0;
         end else begin
            if (pressed_s[i] == level_r) begin
               db_cnt_r <= '0;
            end else if (db_cnt_r == DB_LAST) begin
               db_cnt_r <= '0;
               level_r  <= ~level_r;
            end else begin
               db_cnt_r <= db_cnt_r + DBW'(1);
            end
            press_r   <= press_ev_s;
            release_r <= release_ev_s;
         end
      end

      // Hold/repeat state register with registered strobes.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state_r <= HS_IDLE;
            hcnt_r  <= '0;
            hold_r  <= 1'b0;
            rpt_r   <= 1'b0;
         end else begin
            state_r <= state_nx_s;
            hcnt_r  <= hcnt_nx_s;
            hold_r  <= hold_nx_s;
            rpt_r   <= rpt_nx_s;
         end
      end

      // Hold/repeat next state; a release overrides everything. After hold
      // with repeat disabled the channel parks in IDLE, which cannot leave
      // until a fresh press, i.e. only after a release.
      always_comb begin
         state_nx_s = state_r;
         hcnt_nx_s  = hcnt_r;
         if (release_ev_s) begin
            state_nx_s = HS_IDLE;
            hcnt_nx_s  = '0;
         end else begin
            case (state_r)
               HS_IDLE: begin
                  if (press_ev_s) begin
                     state_nx_s = HS_ARMED;
                     hcnt_nx_s  = '0;
                  end else begin
                     state_nx_s = HS_IDLE;
                     hcnt_nx_s  = '0;
                  end
               end
               HS_ARMED: begin
                  if (hcnt_r == HOLD_LAST) begin
                     state_nx_s = RPT_ON ? HS_REPEAT : HS_IDLE;
                     hcnt_nx_s  = '0;
                  end else begin
                     state_nx_s = HS_ARMED;
                     hcnt_nx_s  = hcnt_r + HW'(1);
                  end
               end
               HS_REPEAT: begin
                  if (hcnt_r == REPEAT_LAST) begin
                     hcnt_nx_s = '0;
                  end else begin
                     hcnt_nx_s = hcnt_r + HW'(1);
                  end
               end
               default: begin
                  state_nx_s = HS_IDLE;
                  hcnt_nx_s  = '0;
               end
            endcase
         end
      end

      // Hold/repeat strobe decode; suppressed in a release cycle.
      always_comb begin
         hold_nx_s = 1'b0;
         rpt_nx_s  = 1'b0;
         if (release_ev_s) begin
            hold_nx_s = 1'b0;
            rpt_nx_s  = 1'b0;
         end else if ((state_r == HS_ARMED) && (hcnt_r == HOLD_LAST)) begin
            hold_nx_s = 1'b1;
            rpt_nx_s  = 1'b0;
         end else if ((state_r == HS_REPEAT) && (hcnt_r == REPEAT_LAST)) begin
            hold_nx_s = 1'b0;
            rpt_nx_s  = RPT_ON;
         end else begin
            hold_nx_s = 1'b0;
            rpt_nx_s  = 1'b0;
         end
      end

      assign btn_level[i] = level_r;
      assign press_o[i]   = press_r;
      assign release_o[i] = release_r;
      assign hold_o[i]    = hold_r;
      assign rpt_o[i]     = rpt_r;
   end

endmodule
